lsu_unit: RTL and testbench

//  Load/store stage of the multi-cycle core, between EXU and the write-back register.

---
 rtl/lsu_unit_pkg.sv | 41 ++++
 rtl/lsu_unit_fmt.sv | 51 +++++
 rtl/lsu_unit.sv | 184 ++++++++++++++++++
 tb/tb_lsu_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_unit_pkg.sv
// Shared types and constants for the load/store unit: funct3 op codes, FSM
// state encoding and small decode helpers used by lsu_unit and lsu_fmt.
package lsu_unit_pkg;

  localparam logic [2:0] LSU_OP_B  = 3'b000;
  localparam logic [2:0] LSU_OP_H  = 3'b001;
  localparam logic [2:0] LSU_OP_W  = 3'b010;
  localparam logic [2:0] LSU_OP_BU = 3'b100;
  localparam logic [2:0] LSU_OP_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'd0,
    LSU_SIZE_H = 2'd1,
    LSU_SIZE_W = 2'd2
  } lsu_size_t;

  // Reserved funct3 codes fall through to word size.
  function automatic lsu_size_t op_size(input logic [2:0] op);
    case (op)
      LSU_OP_B, LSU_OP_BU: op_size = LSU_SIZE_B;
      LSU_OP_H, LSU_OP_HU: op_size = LSU_SIZE_H;
      default:             op_size = LSU_SIZE_W;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op_size(op))
      LSU_SIZE_H: op_misaligned = lane[0];
      LSU_SIZE_W: op_misaligned = |lane;
      default:    op_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_unit_fmt.sv
// Combinational lane logic for lsu_unit: load sign/zero extension and store
// strobe/data alignment, all driven from the low address bits.
module lsu_fmt
  import lsu_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] load_data,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata_lane
);

  logic        [7:0]  byte_raw;
  logic        [15:0] half_raw;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_raw = rdata[{lane, 3'b000} +: 8];
  assign half_raw = rdata[{lane[1], 4'b0000} +: 16];
  assign byte_s   = byte_raw;
  assign half_s   = half_raw;

  // Store data is placed on the same lanes its strobes select.
  always_comb begin
    load_data  = rdata;
    wstrb      = 4'b1111;
    wdata_lane = wdata;
    case (op_size(op))
      LSU_SIZE_B: begin
        load_data  = op[2] ? DATA_W'(byte_raw) : DATA_W'(byte_s);
        wstrb      = 4'b0001 << lane;
        wdata_lane = wdata << {lane, 3'b000};
      end
      LSU_SIZE_H: begin
        load_data  = op[2] ? DATA_W'(half_raw) : DATA_W'(half_s);
        wstrb      = 4'b0011 << {lane[1], 1'b0};
        wdata_lane = wdata << {lane[1], 4'b0000};
      end
      default: begin
        load_data  = rdata;
        wstrb      = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store stage between EXU and WBU: one bus transaction per accepted op.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              mem_ren_i,
  input  logic              mem_wen_i,
  input  logic [2:0]        mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wen_i,
  input  logic              wsel_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              wen_o,
  output logic              wsel_o,
  output logic [4:0]        waddr_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] mem_result_o,
  output logic              err_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  output logic [3:0]        req_wstrb_o,
  input  logic              resp_valid_i,
  input  logic [DATA_W-1:0] resp_rdata_i
);

  lsu_state_t state, state_nxt;

  logic              accept;
  logic              capture;
  logic              mem_op;
  logic              misalign_hit;

  logic              store_p0;
  logic              load_p0;
  logic [2:0]        op_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              wen_p0;
  logic              wsel_p0;
  logic [4:0]        waddr_p0;
  logic [DATA_W-1:0] alu_p0;
  logic [DATA_W-1:0] result_p1;

  logic [DATA_W-1:0] load_data;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata_lane;

  assign mem_op = mem_ren_i | mem_wen_i;

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_p1;

  assign misalign_hit = mem_op & op_misaligned(mem_op_i, addr_i[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_p1 <= 1'b0;
    end else if (accept) begin
      err_p1 <= misalign_hit;
    end
  end

  assign err_o = err_p1;
`else
  assign misalign_hit = 1'b0;
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LSU_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ready_o     = 1'b0;
    req_valid_o = 1'b0;
    valid_o     = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state)
      LSU_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          accept    = 1'b1;
          state_nxt = (mem_op && !misalign_hit) ? LSU_REQ : LSU_DONE;
        end
      end
      LSU_REQ: begin
        req_valid_o = 1'b1;
        if (req_ready_i) begin
          state_nxt = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (resp_valid_i) begin
          capture   = load_p0;
          state_nxt = LSU_DONE;
        end
      end
      LSU_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_nxt = LSU_IDLE;
        end
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  // Request stage: everything EXU hands over is frozen at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_p0 <= 1'b0;
      load_p0  <= 1'b0;
      op_p0    <= 3'b000;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      wen_p0   <= 1'b0;
      wsel_p0  <= 1'b0;
      waddr_p0 <= 5'd0;
      alu_p0   <= '0;
    end else if (accept) begin
      store_p0 <= mem_wen_i;
      load_p0  <= mem_ren_i & ~mem_wen_i;
      op_p0    <= mem_op_i;
      addr_p0  <= addr_i;
      wdata_p0 <= wdata_i;
      wen_p0   <= wen_i & ~misalign_hit;
      wsel_p0  <= wsel_i;
      waddr_p0 <= waddr_i;
      alu_p0   <= alu_result_i;
    end
  end

  // Result stage: cleared on accept so stores and non-mem ops report zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_p1 <= '0;
    end else if (accept) begin
      result_p1 <= '0;
    end else if (capture) begin
      result_p1 <= load_data;
    end
  end

  lsu_fmt #(.DATA_W(DATA_W)) u_fmt (
    .op         (op_p0),
    .lane       (addr_p0[1:0]),
    .wdata      (wdata_p0),
    .rdata      (resp_rdata_i),
    .load_data  (load_data),
    .wstrb      (wstrb),
    .wdata_lane (wdata_lane)
  );

  assign req_we_o     = store_p0;
  assign req_addr_o   = addr_p0;
  assign req_wdata_o  = store_p0 ? wdata_lane : '0;
  assign req_wstrb_o  = store_p0 ? wstrb : 4'b0000;
  assign mem_result_o = result_p1;
  assign wen_o        = wen_p0;
  assign wsel_o       = wsel_p0;
  assign waddr_o      = waddr_p0;
  assign alu_result_o = alu_p0;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed self-checking bench for lsu_unit; expectations are hand-computed.
module tb_lsu_unit;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        mem_ren_i;
  logic        mem_wen_i;
  logic [2:0]  mem_op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        wen_i;
  logic        wsel_i;
  logic [4:0]  waddr_i;
  logic [31:0] alu_result_i;
  logic        wen_o;
  logic        wsel_o;
  logic [4:0]  waddr_o;
  logic [31:0] alu_result_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] mem_result_o;
  logic        err_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic [3:0]  req_wstrb_o;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;

  int total = 0;
  int bad   = 0;
  int cyc;

  logic        saw_req;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  lsu_unit dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .mem_ren_i    (mem_ren_i),
    .mem_wen_i    (mem_wen_i),
    .mem_op_i     (mem_op_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .wen_i        (wen_i),
    .wsel_i       (wsel_i),
    .waddr_i      (waddr_i),
    .alu_result_i (alu_result_i),
    .wen_o        (wen_o),
    .wsel_o       (wsel_o),
    .waddr_o      (waddr_o),
    .alu_result_o (alu_result_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .mem_result_o (mem_result_o),
    .err_o        (err_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_we_o     (req_we_o),
    .req_addr_o   (req_addr_o),
    .req_wdata_o  (req_wdata_o),
    .req_wstrb_o  (req_wstrb_o),
    .resp_valid_i (resp_valid_i),
    .resp_rdata_i (resp_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op with an always-ready bus that answers one cycle after the
  // request handshake; stops once valid_o rises (bounded), ready_i held low.
  task automatic run_op(input logic ren, input logic wen, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, output int n);
    logic fired;
    mem_ren_i    = ren;
    mem_wen_i    = wen;
    mem_op_i     = op;
    addr_i       = addr;
    wdata_i      = wdata;
    resp_rdata_i = rdata;
    req_ready_i  = 1'b1;
    ready_i      = 1'b0;
    valid_i      = 1'b1;
    saw_req      = 1'b0;
    n            = 0;
    do begin
      fired = req_valid_o & req_ready_i;
      if (req_valid_o) begin
        saw_req   = 1'b1;
        cap_we    = req_we_o;
        cap_addr  = req_addr_o;
        cap_wdata = req_wdata_o;
        cap_wstrb = req_wstrb_o;
      end
      tick();
      n++;
      if (n == 1) begin
        valid_i   = 1'b0;
        addr_i    = 32'hDEAD_BEE0;
        wdata_i   = 32'h5555_5555;
      end
      resp_valid_i = fired;
    end while (!valid_o && n < 20);
    resp_valid_i = 1'b0;
  endtask

  task automatic release_done(input string tag);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check({tag, "_ready_after"}, {31'd0, ready_o}, 32'd1);
    check({tag, "_valid_after"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; mem_ren_i = 1'b0; mem_wen_i = 1'b0; mem_op_i = 3'b000;
    addr_i = '0; wdata_i = '0; wen_i = 1'b0; wsel_i = 1'b0; waddr_i = 5'd0;
    alu_result_i = '0; ready_i = 1'b0; req_ready_i = 1'b0; resp_valid_i = 1'b0;
    resp_rdata_i = '0; saw_req = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
    cap_wstrb = '0;
    tick();
    tick();
    check("rst_ready",   {31'd0, ready_o},     32'd1);
    check("rst_valid",   {31'd0, valid_o},     32'd0);
    check("rst_reqv",    {31'd0, req_valid_o}, 32'd0);
    check("rst_result",  mem_result_o,         32'd0);
    check("rst_err",     {31'd0, err_o},       32'd0);
    check("rst_wstrb",   {28'd0, req_wstrb_o}, 32'd0);
    check("rst_addr",    req_addr_o,           32'd0);
    rst = 1'b1;
    tick();

    // LB with pass-through fields
    wen_i = 1'b1; wsel_i = 1'b1; waddr_i = 5'd5; alu_result_i = 32'h0000_1234;
    run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, cyc);
    check("lb_latency", cyc,                    32'd3);
    check("lb_result",  mem_result_o,           32'hFFFF_FF80);
    check("lb_req_we",  {31'd0, cap_we},        32'd0);
    check("lb_wstrb",   {28'd0, cap_wstrb},     32'd0);
    check("lb_addr",    cap_addr,               32'h8000_0003);
    check("lb_wen_o",   {31'd0, wen_o},         32'd1);
    check("lb_wsel_o",  {31'd0, wsel_o},        32'd1);
    check("lb_waddr_o", {27'd0, waddr_o},       32'd5);
    check("lb_alu_o",   alu_result_o,           32'h0000_1234);
    check("lb_ready_o", {31'd0, ready_o},       32'd0);
    release_done("lb");

    run_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, cyc);
    check("lbu_result", mem_result_o, 32'h0000_0080);
    release_done("lbu");

    run_op(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_1234, cyc);
    check("lhu_result", mem_result_o, 32'h0000_BEEF);
    release_done("lhu");

    run_op(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'hBEEF_1234, cyc);
    check("lh_result", mem_result_o, 32'hFFFF_BEEF);
    release_done("lh");

    run_op(1'b1, 1'b0, 3'b011, 32'h8000_0004, 32'h0, 32'hCAFE_F00D, cyc);
    check("lres_result", mem_result_o, 32'hCAFE_F00D);
    release_done("lres");

    run_op(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'hFFFF_FFFF, cyc);
    check("sb_latency", cyc,                32'd3);
    check("sb_wstrb",   {28'd0, cap_wstrb}, 32'h2);
    check("sb_wdata",   cap_wdata,          32'h0000_AB00);
    check("sb_we",      {31'd0, cap_we},    32'd1);
    check("sb_result",  mem_result_o,       32'd0);
    release_done("sb");

    run_op(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, cyc);
    check("sh_wstrb", {28'd0, cap_wstrb}, 32'hC);
    check("sh_wdata", cap_wdata,          32'hBEEF_0000);
    release_done("sh");

    run_op(1'b1, 1'b1, 3'b010, 32'h8000_0008, 32'h1122_3344, 32'hFFFF_FFFF, cyc);
    check("rw_we",     {31'd0, cap_we},    32'd1);
    check("rw_wstrb",  {28'd0, cap_wstrb}, 32'hF);
    check("rw_wdata",  cap_wdata,          32'h1122_3344);
    check("rw_result", mem_result_o,       32'd0);
    release_done("rw");

    waddr_i = 5'd9; alu_result_i = 32'h0BAD_F00D;
    run_op(1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h0, cyc);
    check("nomem_latency", cyc,              32'd1);
    check("nomem_saw_req", {31'd0, saw_req}, 32'd0);
    check("nomem_result",  mem_result_o,     32'd0);
    check("nomem_alu_o",   alu_result_o,     32'h0BAD_F00D);
    release_done("nomem");

    // Backpressure on both bus and WBU
    mem_ren_i = 1'b0; mem_wen_i = 1'b1; mem_op_i = 3'b010; addr_i = 32'h8000_0010;
    wdata_i = 32'h1234_5678; waddr_i = 5'd7; req_ready_i = 1'b0; ready_i = 1'b0;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_reqv",  {31'd0, req_valid_o}, 32'd1);
      check("bp_addr",  req_addr_o,           32'h8000_0010);
      check("bp_wdata", req_wdata_o,          32'h1234_5678);
      check("bp_wstrb", {28'd0, req_wstrb_o}, 32'hF);
      check("bp_ready", {31'd0, ready_o},     32'd0);
      tick();
    end
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    check("bp_wait_reqv", {31'd0, req_valid_o}, 32'd0);
    resp_valid_i = 1'b1;
    tick();
    resp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_done_valid",  {31'd0, valid_o}, 32'd1);
      check("bp_done_result", mem_result_o,     32'd0);
      check("bp_done_waddr",  {27'd0, waddr_o}, 32'd7);
      check("bp_done_ready",  {31'd0, ready_o}, 32'd0);
      tick();
    end
    release_done("bp");

    // Async reset while waiting for a response
    mem_ren_i = 1'b1; mem_wen_i = 1'b0; mem_op_i = 3'b010; addr_i = 32'h8000_0020;
    waddr_i = 5'd3; req_ready_i = 1'b1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    req_ready_i = 1'b0;
    check("ar_in_wait_reqv", {31'd0, req_valid_o}, 32'd0);
    check("ar_in_wait_rdy",  {31'd0, ready_o},     32'd0);
    #2 rst = 1'b0;
    #1;
    check("ar_ready", {31'd0, ready_o},     32'd1);
    check("ar_valid", {31'd0, valid_o},     32'd0);
    check("ar_reqv",  {31'd0, req_valid_o}, 32'd0);
    check("ar_addr",  req_addr_o,           32'd0);
    check("ar_waddr", {27'd0, waddr_o},     32'd0);
    #1 rst = 1'b1;
    resp_valid_i = 1'b1; resp_rdata_i = 32'hFFFF_FFFF;
    tick();
    resp_valid_i = 1'b0;
    check("ar_late_valid",  {31'd0, valid_o}, 32'd0);
    check("ar_late_ready",  {31'd0, ready_o}, 32'd1);
    check("ar_late_result", mem_result_o,     32'd0);

    // Misaligned word load
    wen_i = 1'b1;
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1357_9BDF, cyc);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_latency", cyc,              32'd1);
    check("mis_saw_req", {31'd0, saw_req}, 32'd0);
    check("mis_err",     {31'd0, err_o},   32'd1);
    check("mis_result",  mem_result_o,     32'd0);
    check("mis_wen_o",   {31'd0, wen_o},   32'd0);
`else
    check("mis_latency", cyc,              32'd3);
    check("mis_saw_req", {31'd0, saw_req}, 32'd1);
    check("mis_addr",    cap_addr,         32'h8000_0002);
    check("mis_err",     {31'd0, err_o},   32'd0);
    check("mis_result",  mem_result_o,     32'h1357_9BDF);
`endif
    release_done("mis");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
